// File: rtl/issue_stage.sv
// issue_stage: decode, register read and writeback stage feeding a one-cycle registered ALU.
// Stalls one cycle on a read-after-write to the previous instruction, and bypasses alu_out otherwise.
module issue_stage #(
   parameter int NREGS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [15:0] operA,
   output logic [15:0] operB,
   output logic [3:0]  alu_op,
   input  logic [15:0] alu_out,
   input  logic [3:0]  flags,
   output logic [3:0]  status_flags,
   input  logic [2:0]  dbg_rsel,
   output logic [15:0] dbg_rdata
);
   logic [15:0] regs [NREGS];
   logic        s1_v, s2_v;
   logic [2:0]  s1_rd, s2_rd;
   logic [3:0]  op;
   logic [2:0]  rd, ra, rb;
   logic        is_ldi, is_alu, hazard, accept, unused_bits;
   logic [15:0] rdat_a, rdat_b;
   assign op = instr[15:12];
   assign rd = instr[11:9];
   assign ra = instr[8:6];
   assign rb = instr[5:3];
   assign unused_bits = ^instr[2:0];
   assign is_ldi = op == 4'd0;
   assign is_alu = op == 4'd15 || (op != 4'd0 && op < 4'd8);
   // s1 result is still inside the ALU, so a dependent ALU op must wait one cycle
   assign hazard = instr_valid && s1_v && is_alu && (ra == s1_rd || rb == s1_rd);
   assign instr_ready = !rst && !hazard;
   assign accept = instr_valid && instr_ready;
   // s2 result is on alu_out now and lands in the file at this same edge
   assign rdat_a = (s2_v && ra == s2_rd) ? alu_out : regs[ra];
   assign rdat_b = (s2_v && rb == s2_rd) ? alu_out : regs[rb];
   assign dbg_rdata = regs[dbg_rsel];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         operA        <= '0;
         operB        <= '0;
         alu_op       <= '0;
         status_flags <= '0;
         s1_v         <= 1'b0;
         s1_rd        <= '0;
         s2_v         <= 1'b0;
         s2_rd        <= '0;
      end else begin
         alu_op <= !accept ? 4'd0 : is_alu ? op : is_ldi ? 4'd4 : 4'd0;
         operA  <= !accept ? 16'd0 : is_alu ? rdat_a : is_ldi ? {7'b0, instr[8:0]} : 16'd0;
         operB  <= (accept && is_alu) ? rdat_b : 16'd0;
         s1_v   <= accept && (is_alu || is_ldi);
         s1_rd  <= rd;
         s2_v   <= s1_v;
         s2_rd  <= s1_rd;
         if (s2_v) begin
            regs[s2_rd]  <= alu_out;
            status_flags <= flags;
         end
      end
   end
endmodule

// File: tb/tb_issue_stage.sv
// tb_issue_stage: drives issue_stage with a registered ALU model, checks against an
// in-order architectural model with delayed visibility, plus directed literal checks.
module tb_issue_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] operA, operB, alu_out, dbg_rdata;
   logic [3:0]  alu_op, flags, status_flags;
   logic [2:0]  dbg_rsel = '0;
   int total = 0;
   int bad = 0;

   issue_stage #(.NREGS(8)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .operA(operA), .operB(operB), .alu_op(alu_op),
      .alu_out(alu_out), .flags(flags), .status_flags(status_flags),
      .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata)
   );

   always #5 clk = ~clk;

   // ALU: {carry, negative, overflow, zero, result}; SUB is B-A
   function automatic logic [19:0] alu_f(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] r;
      logic        v;
      r = '0;
      v = 1'b0;
      case (o)
         4'd1: begin r = {1'b0, a} + {1'b0, b}; v = (a[15] == b[15]) && (r[15] != a[15]); end
         4'd2: begin r = {1'b0, b} + {1'b0, ~a} + 17'd1; v = (a[15] != b[15]) && (r[15] != b[15]); end
         4'd3: r = {1'b0, a & b};
         4'd4: r = {1'b0, a | b};
         4'd5: r = {1'b0, a ^ b};
         4'd6: r = {a, 1'b0};
         4'd7: r = {2'b0, b[15:1]};
         4'd15: r = {1'b0, ~a};
         default: r = '0;
      endcase
      return {r[16], r[15], v, r[15:0] == 16'd0, r[15:0]};
   endfunction

   always @(posedge clk) {flags, alu_out} <= alu_f(alu_op, operA, operB);

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: arch holds in-order results at accept time; vis is what the file shows once a write matures
   typedef struct {
      int          due;
      logic [2:0]  rd;
      logic [15:0] val;
      logic [3:0]  fl;
   } wb_t;
   wb_t         q[$];
   logic [15:0] arch [8];
   logic [15:0] vis [8];
   logic [15:0] m_a, m_b;
   logic [3:0]  m_op, m_sf, o;
   logic [19:0] r;
   bit          acc;
   int          cyc = 0;

   function automatic bit hz(input logic [15:0] w);
      logic [3:0] wo;
      wo = w[15:12];
      if (!(wo == 4'd15 || (wo >= 4'd1 && wo <= 4'd7))) return 1'b0;
      foreach (q[i]) if (q[i].due == cyc + 2 && (q[i].rd == w[8:6] || q[i].rd == w[5:3])) return 1'b1;
      return 1'b0;
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         q.delete();
         foreach (arch[i]) arch[i] = '0;
         foreach (vis[i]) vis[i] = '0;
         m_a = '0; m_b = '0; m_op = '0; m_sf = '0;
      end else begin
         acc = instr_valid && !hz(instr);
         cyc++;
         while (q.size() > 0 && q[0].due == cyc) begin
            vis[q[0].rd] = q[0].val;
            m_sf = q[0].fl;
            void'(q.pop_front());
         end
         m_op = '0; m_a = '0; m_b = '0;
         if (acc) begin
            o = instr[15:12];
            if (o == 4'd0) begin
               m_op = 4'd4;
               m_a = {7'b0, instr[8:0]};
            end else if (o == 4'd15 || o < 4'd8) begin
               m_op = o;
               m_a = arch[instr[8:6]];
               m_b = arch[instr[5:3]];
            end
            if (o == 4'd15 || o < 4'd8) begin
               r = alu_f(m_op, m_a, m_b);
               arch[instr[11:9]] = r[15:0];
               q.push_back('{cyc + 2, instr[11:9], r[15:0], r[19:16]});
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst) begin
         chk("rst_ready", 16'(instr_ready), 16'd0);
         chk("rst_alu_op", 16'(alu_op), 16'd0);
         chk("rst_operA", operA, 16'd0);
         chk("rst_operB", operB, 16'd0);
         chk("rst_status", 16'(status_flags), 16'd0);
         chk("rst_dbg", dbg_rdata, 16'd0);
      end else begin
         chk("ready", 16'(instr_ready), 16'(!(instr_valid && hz(instr))));
         chk("alu_op", 16'(alu_op), 16'(m_op));
         chk("operA", operA, m_a);
         chk("operB", operB, m_b);
         chk("status", 16'(status_flags), 16'(m_sf));
         chk("dbg", dbg_rdata, vis[dbg_rsel]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   bit hold;
   initial begin
      repeat (2) step();
      for (int i = 0; i < 8; i++) begin
         dbg_rsel = 3'(i);
         #1 chk("d_rst_reg", dbg_rdata, 16'd0);
      end
      chk("d_rst_ready", 16'(instr_ready), 16'd0);
      chk("d_rst_alu_op", 16'(alu_op), 16'd0);
      rst = 1'b0;
      step();
      instr = 16'h0205; instr_valid = 1'b1;
      #1 chk("d_ldi1_ready", 16'(instr_ready), 16'd1);
      step();
      chk("d_ldi1_op", 16'(alu_op), 16'd4);
      chk("d_ldi1_a", operA, 16'd5);
      chk("d_ldi1_b", operB, 16'd0);
      instr = 16'h0403;
      #1 chk("d_ldi2_ready", 16'(instr_ready), 16'd1);
      step();
      chk("d_ldi2_a", operA, 16'd3);
      instr = 16'h1650;
      #1 chk("d_stall", 16'(instr_ready), 16'd0);
      step();
      dbg_rsel = 3'd1;
      #1 chk("d_r1", dbg_rdata, 16'd5);
      chk("d_unstall", 16'(instr_ready), 16'd1);
      chk("d_bubble_op", 16'(alu_op), 16'd0);
      step();
      instr_valid = 1'b0;
      chk("d_add_op", 16'(alu_op), 16'd1);
      chk("d_add_a", operA, 16'd5);
      chk("d_add_b", operB, 16'd3);
      dbg_rsel = 3'd2;
      #1 chk("d_r2", dbg_rdata, 16'd3);
      step();
      step();
      dbg_rsel = 3'd3;
      #1 chk("d_r3", dbg_rdata, 16'd8);
      chk("d_add_flags", 16'(status_flags), 16'd0);
      instr = 16'h2850; instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      chk("d_sub_op", 16'(alu_op), 16'd2);
      chk("d_sub_a", operA, 16'd5);
      chk("d_sub_b", operB, 16'd3);
      step();
      step();
      dbg_rsel = 3'd4;
      #1 chk("d_r4", dbg_rdata, 16'hFFFE);
      chk("d_sub_flags", 16'(status_flags), 16'h4);
      instr = 16'h9FFF; instr_valid = 1'b1;
      #1 chk("d_nop_ready", 16'(instr_ready), 16'd1);
      step();
      instr_valid = 1'b0;
      chk("d_nop_op", 16'(alu_op), 16'd0);
      chk("d_nop_a", operA, 16'd0);
      step();
      step();
      chk("d_nop_flags", 16'(status_flags), 16'h4);
      dbg_rsel = 3'd7;
      #1 chk("d_nop_r7", dbg_rdata, 16'd0);
      instr = 16'h1A50; instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      rst = 1'b1;
      #1 chk("d_midrst_op", 16'(alu_op), 16'd0);
      step();
      rst = 1'b0;
      step();
      step();
      dbg_rsel = 3'd5;
      #1 chk("d_midrst_r5", dbg_rdata, 16'd0);
      chk("d_midrst_flags", 16'(status_flags), 16'd0);
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         hold = instr_valid && !instr_ready;
         @(posedge clk);
         #1;
         if (!hold) begin
            instr_valid = $urandom_range(0, 3) != 0;
            instr = 16'($urandom);
         end
         dbg_rsel = 3'($urandom);
         rst = $urandom_range(0, 299) == 0;
      end
      rst = 1'b0;
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/issue_stage.md
# issue_stage

Decode, register-read and writeback stage directly upstream of the pipeline CPU's ALU. Accepts 16-bit instructions over a valid/ready handshake, reads an 8×16 register file, and drives the ALU's registered operand/opcode inputs. It writes `alu_out` back into the register file when the result returns, and latches the ALU flags. It provides a one-cycle stall and a bypass path to handle the ALU's one-cycle registered latency.

## Interface
- `NREGS`, 8: register count; fixed at 8 because of the 3-bit register fields.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 16: instruction word.
- `instr_valid` in 1: `instr` is valid this cycle.
- `instr_ready` out 1: stage accepts `instr` this cycle (combinational).
- `operA` out 16: ALU operand A (registered).
- `operB` out 16: ALU operand B (registered).
- `alu_op` out 4: ALU opcode (registered); 0 means idle.
- `alu_out` in 16: ALU result; valid one cycle after `alu_op` is driven.
- `flags` in 4: ALU flags {carry, negative, overflow, zero}, aligned with `alu_out`.
- `status_flags` out 4: flags of the last written-back instruction.
- `dbg_rsel` in 3: debug register select.
- `dbg_rdata` out 16: register file content at `dbg_rsel` (combinational, no bypass).

## Operation
- **Encoding:** `op`=[15:12], `rd`=[11:9], `ra`=[8:6], `rb`=[5:3]; bits [2:0] are ignored.
- **ALU ops (1–7, 15):**
  - Issue `alu_op`=`op`, `operA`=R[`ra`], `operB`=R[`rb`]. Writeback target is `rd`.
  - SUB computes `operB`−`operA`.
  - SHL uses `operA`; SHR uses `operB`; NOT uses `operA`.
- **LDI (op 0):**
  - Issue `alu_op`=4 (OR), `operA`={7'b0, `instr`[8:0]}, `operB`=0. Writeback target is `rd`.
  - Never reads the register file.
- **NOP (ops 8–14):** accepted; `alu_op`=0, `operA`=`operB`=0; no writeback.
- **Accept:** an instruction is accepted at an edge where `instr_valid` and `instr_ready` are both high.
- **Idle cycle:** at any edge with no accept, `alu_op`, `operA` and `operB` are driven to 0.
- **Writeback tracking:**
  - `s1` (valid, rd) is set for the instruction issued at edge k.
  - At edge k+1, `s1` moves to `s2`.
  - At edge k+2, R[`s2.rd`] ← `alu_out` and `status_flags` ← `flags`.
- **Hazard:**
  - `instr_ready`=0 when `instr_valid`, `s1.valid`, `op` is an ALU op, and (`ra`==`s1.rd` or `rb`==`s1.rd`).
  - LDI and NOP never stall.
  - A stall costs exactly one cycle.
- **Bypass:** when an operand read index equals `s2.rd` with `s2.valid`, the operand takes `alu_out` instead of the register file. This covers the same-edge writeback.
- **Write-after-write:** `s1` and `s2` targeting the same register is legal; writes are in order.
- **Registers:** all 8 registers are writable; none is hardwired to zero.
- **`status_flags`:** unchanged by NOP or idle cycles.

## Timing
- **Reset (asynchronous):**
  - `operA`, `operB`, `alu_op`, `status_flags` = 0.
  - All registers = 0.
  - `s1` and `s2` are invalidated.
  - `instr_ready` is forced to 0 while `rst` is high.
- **After reset deasserts:** `instr_ready`=1 (no pending writeback).
- **Latency:**
  - Accept at edge k → ALU inputs valid after k.
  - `alu_out` valid after k+1.
  - Register file updated at k+2.
- **Throughput:** one instruction per cycle, except a one-cycle bubble on a read-after-write to the immediately preceding instruction.
- **Reset mid-flight:** pending `s1`/`s2` writebacks are discarded; no register changes.
- **`dbg_rdata`:** reflects the register file after the k+2 write edge.

## Test plan
1. **Reset:** assert `rst` mid-run → `operA`=`operB`=0, `alu_op`=0, `status_flags`=0, `instr_ready`=0; every `dbg_rsel` reads 0.
2. **Back-to-back LDI:** LDI r1,5 then LDI r2,3 on consecutive cycles →
   - No stall.
   - ALU sees `alu_op`=4, `operA`=5, `operB`=0, then `operA`=3.
   - R1=5 two edges after the first accept, R2=3 one edge later.
3. **Stall and bypass:** ADD r3,r1,r2 presented immediately after LDI r2,3 →
   - `instr_ready`=0 for one cycle.
   - Then accepted with `alu_op`=1, `operA`=5, `operB`=3 (R2 via bypass).
   - R3=8; `status_flags`=0.
4. **SUB negative:** SUB r4,ra=r1,rb=r2 (R1=5, R2=3) → `alu_op`=2; R4=16'hFFFE; `status_flags`=4'b0100.
5. **NOP:** `instr`=16'h9FFF → accepted; `alu_op`=0; no register changes; `status_flags` holds its previous value.
6. **Reset mid-flight:** ADD r5,r1,r2 accepted, then `rst` pulsed the next cycle → R5 remains 0; `status_flags`=0.
